// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: read-side burst controller for a simple dual-port RAM.
// It accepts a (start address, length) burst command and issues one RAM read
// per cycle on port B. Read data passes through an in-flight tag pipe into a
// small return FIFO and leaves as a valid/ready stream with a last-beat flag.
//
// Handshake rule for both the command and the data stream: a transfer
// happens on a rising edge where valid and ready are both high. The source
// keeps its payload stable while valid is high and ready is low. Valid never
// depends combinationally on ready.
module ram_rd_streamer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [ADDR_W-1:0] i_cmd_len,
    output logic              o_enb,
    output logic [ADDR_W-1:0] o_addrb,
    input  logic [DATA_W-1:0] i_doutb,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_last,
    output logic              o_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rem_q;
    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [RD_LAT-1:0]   pipe_last_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       cnt_q;

    logic [SW-1:0]       in_flight;
    logic                credit_ok;
    logic                enb;
    logic                push;
    logic                pop;
    logic                last_hs;

    // Count reads that have been issued but whose data has not reached the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + SW'(pipe_vld_q[i]);
        end
    end

    // A read may only issue if the FIFO has room reserved for every outstanding word.
    assign credit_ok = (in_flight + SW'(cnt_q)) < SW'(FIFO_DEPTH);
    assign enb       = (state_q == READ) && credit_ok;
    assign push      = pipe_vld_q[RD_LAT-1];
    assign pop       = (cnt_q != '0) && i_data_ready;
    assign last_hs   = pop && mem_last_q[rd_ptr_q];

    assign o_cmd_ready  = (state_q == IDLE);
    assign o_busy       = (state_q != IDLE);
    assign o_enb        = enb;
    assign o_addrb      = addr_q;
    assign o_data_valid = (cnt_q != '0);
    assign o_data       = mem_q[rd_ptr_q];
    assign o_data_last  = mem_last_q[rd_ptr_q];

    // Burst FSM: latch the command, walk the address and length, wait for the last beat.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        rem_q   <= i_cmd_len;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (enb) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (rem_q == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            rem_q <= rem_q - ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // In-flight tag pipe: mirrors the RAM read latency so the tail lines up with i_doutb.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= enb;
            pipe_last_q[0] <= enb && (rem_q == '0);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    // Return FIFO: captures RAM data at the pipe tail and feeds the output stream.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            mem_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]      <= i_doutb;
                mem_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer: two instances (read latency 1 and 2) share the
// command and stream-ready inputs, each with its own RAM model, expected
// word queue and expected address queue.
module tb_ram_rd_streamer;

    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic ready;

    logic rdy1, enb1, vld1, last1, busy1;
    logic [7:0] addrb1;
    logic [15:0] doutb1, data1;
    logic rdy2, enb2, vld2, last2, busy2;
    logic [7:0] addrb2;
    logic [15:0] doutb2, data2, stage2;

    logic [15:0] ram [256];

    logic [16:0] exp1_q[$];
    logic [16:0] exp2_q[$];
    logic [7:0]  eaddr1_q[$];
    logic [7:0]  eaddr2_q[$];

    int checks = 0;
    int errors = 0;
    int beats1 = 0;
    int beats2 = 0;
    int out1 = 0;
    int out2 = 0;
    logic prev_v1 = 1'b0;
    logic prev_v2 = 1'b0;
    logic prev_r = 1'b1;
    logic [16:0] prev_w1 = '0;
    logic [16:0] prev_w2 = '0;

    always #5 clk = ~clk;

    ram_rd_streamer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(FD)) u_dut1 (
        .i_sys_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy1),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .o_enb(enb1), .o_addrb(addrb1), .i_doutb(doutb1),
        .o_data_valid(vld1), .i_data_ready(ready),
        .o_data(data1), .o_data_last(last1), .o_busy(busy1)
    );

    ram_rd_streamer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2), .FIFO_DEPTH(FD)) u_dut2 (
        .i_sys_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy2),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .o_enb(enb2), .o_addrb(addrb2), .i_doutb(doutb2),
        .o_data_valid(vld2), .i_data_ready(ready),
        .o_data(data2), .o_data_last(last2), .o_busy(busy2)
    );

    // RAM model, latency 1 (no output register)
    always @(posedge clk) begin
        if (enb1) doutb1 <= ram[addrb1];
    end

    // RAM model, latency 2 (output register enabled)
    always @(posedge clk) begin
        if (enb2) stage2 <= ram[addrb2];
        doutb2 <= stage2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: address order, credit bound, stream beats and stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_v1 && !prev_r) begin
                chk("hold_vld1", 32'(vld1), 1);
                chk("hold_word1", 32'({last1, data1}), 32'(prev_w1));
            end
            if (prev_v2 && !prev_r) begin
                chk("hold_vld2", 32'(vld2), 1);
                chk("hold_word2", 32'({last2, data2}), 32'(prev_w2));
            end
            if (enb1) begin
                chk("credit1", 32'(out1 < FD), 1);
                if (eaddr1_q.size() == 0) chk("unexp_enb1", 32'(enb1), 0);
                else chk("addrb1", 32'(addrb1), 32'(eaddr1_q.pop_front()));
                out1++;
            end
            if (enb2) begin
                chk("credit2", 32'(out2 < FD), 1);
                if (eaddr2_q.size() == 0) chk("unexp_enb2", 32'(enb2), 0);
                else chk("addrb2", 32'(addrb2), 32'(eaddr2_q.pop_front()));
                out2++;
            end
            if (vld1 && ready) begin
                if (exp1_q.size() == 0) chk("unexp_beat1", 32'(vld1), 0);
                else chk("beat1", 32'({last1, data1}), 32'(exp1_q.pop_front()));
                beats1++;
                out1--;
            end
            if (vld2 && ready) begin
                if (exp2_q.size() == 0) chk("unexp_beat2", 32'(vld2), 0);
                else chk("beat2", 32'({last2, data2}), 32'(exp2_q.pop_front()));
                beats2++;
                out2--;
            end
            prev_v1 = vld1;
            prev_v2 = vld2;
            prev_w1 = {last1, data1};
            prev_w2 = {last2, data2};
            prev_r  = ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready1", 32'(rdy1), 1);
        chk("rst_enb1", 32'(enb1), 0);
        chk("rst_addrb1", 32'(addrb1), 0);
        chk("rst_valid1", 32'(vld1), 0);
        chk("rst_last1", 32'(last1), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_data1", 32'(data1), 0);
        chk("rst_cmd_ready2", 32'(rdy2), 1);
        chk("rst_enb2", 32'(enb2), 0);
        chk("rst_addrb2", 32'(addrb2), 0);
        chk("rst_valid2", 32'(vld2), 0);
        chk("rst_last2", 32'(last2), 0);
        chk("rst_busy2", 32'(busy2), 0);
        chk("rst_data2", 32'(data2), 0);
    endtask

    // Issue one command to both instances; returns in the cycle after acceptance.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
        int n;
        logic [7:0] ad;
        n = 0;
        while ((busy1 || busy2) && n < 2000) begin
            step();
            n++;
        end
        if (busy1 || busy2) chk("cmd_wait_idle", 32'(busy1 | busy2), 0);
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + 8'(i);
            exp1_q.push_back({(i == int'(l)), ram[ad]});
            exp2_q.push_back({(i == int'(l)), ram[ad]});
            eaddr1_q.push_back(ad);
            eaddr2_q.push_back(ad);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        chk("cmd_ready1", 32'(rdy1), 1);
        chk("cmd_ready2", 32'(rdy2), 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy1 || busy2 || exp1_q.size() != 0 || exp2_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        chk("done_busy", 32'(busy1 | busy2), 0);
        chk("done_pending", 32'(exp1_q.size() + exp2_q.size()), 0);
        repeat (3) step();
    endtask

    initial begin
        int b0;
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
        ram[8'h10] = 16'hA5A5;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        ready     = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset_vals();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Single word: read issued in cycle N, data in N+2, busy drops after handshake
        send_cmd(8'h10, 8'h00);
        chk("t1_enb", 32'(enb1), 1);
        chk("t1_addrb", 32'(addrb1), 32'h10);
        step();
        chk("t1_vld_early", 32'(vld1), 0);
        chk("t1_enb_once", 32'(enb1), 0);
        step();
        chk("t1_vld", 32'(vld1), 1);
        chk("t1_data", 32'(data1), 32'hA5A5);
        chk("t1_last", 32'(last1), 1);
        chk("t1_busy", 32'(busy1), 1);
        step();
        chk("t1_busy_low", 32'(busy1), 0);
        wait_done();

        // Full-rate burst: four back-to-back beats 0x60,0x63,0x66,0x69
        send_cmd(8'h20, 8'h03);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t2_fullrate_vld", 32'(vld1), 1);
            step();
        end
        wait_done();

        // Backpressure: ready low for 8 cycles after beat 2
        b0 = beats1;
        send_cmd(8'h00, 8'h0F);
        n = 0;
        while (beats1 - b0 < 2 && n < 200) begin
            step();
            n++;
        end
        chk("t3_two_beats", 32'(beats1 - b0 >= 2), 1);
        ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                chk("t3_enb1_stopped", 32'(enb1), 0);
                chk("t3_enb2_stopped", 32'(enb2), 0);
                chk("t3_vld1_stalled", 32'(vld1), 1);
            end
            step();
        end
        ready = 1'b1;
        wait_done();

        // Address wrap 0xFE,0xFF,0x00
        send_cmd(8'hFE, 8'h02);
        wait_done();

        // Maximum length, plus a command presented mid-burst that must be ignored
        b0 = beats1;
        send_cmd(8'h00, 8'hFF);
        repeat (20) step();
        cmd_valid = 1'b1;
        cmd_addr  = 8'h80;
        cmd_len   = 8'h00;
        for (int k = 0; k < 3; k++) begin
            chk("t5_ignored_ready1", 32'(rdy1), 0);
            chk("t5_ignored_ready2", 32'(rdy2), 0);
            step();
        end
        cmd_valid = 1'b0;
        wait_done();
        chk("t5_beats", 32'(beats1 - b0), 256);

        // Reset mid-burst after 5 beats, then a fresh single-word command
        b0 = beats1;
        send_cmd(8'h00, 8'h1F);
        n = 0;
        while (beats1 - b0 < 5 && n < 200) begin
            step();
            n++;
        end
        #1 rst_n = 1'b0;
        exp1_q.delete();
        exp2_q.delete();
        eaddr1_q.delete();
        eaddr2_q.delete();
        out1 = 0;
        out2 = 0;
        prev_v1 = 1'b0;
        prev_v2 = 1'b0;
        #1 chk_reset_vals();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("t6_no_stale1", 32'(vld1), 0);
            chk("t6_no_stale2", 32'(vld2), 0);
            step();
        end
        b0 = beats1;
        send_cmd(8'h40, 8'h00);
        wait_done();
        chk("t6_one_beat", 32'(beats1 - b0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
